fdtd_sweep_ctrl: RTL and testbench
==================================

FDTD_SWEEP_CTRL -- requirements
Module: fdtd_sweep_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: cell-index width.
REQ-002 SHALL have parameter TSTEP_WIDTH, default 16: timestep-counter width.
REQ-003 SHALL have parameter CALC_LAT, default 2 (legal 1..8): cycles from a calc enable to the matching result at the downstream calc stage.
REQ-004 SHALL have ports:
- CLK  in  1  sole clock, rising edge
- RST  in  1  synchronous, active-high reset
- start_i  in  1  run request
- num_cells_i  in  ADDR_WIDTH  grid size N
- num_steps_i  in  TSTEP_WIDTH  timesteps to run
- src_idx_i  in  ADDR_WIDTH  source cell
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse
- calc_Hy_en_o  out  1  Hy update enable
- calc_Ez_en_o  out  1  Ez update enable
- calc_src_en_o  out  1  source-injection enable
- rd_addr_o  out  ADDR_WIDTH  field read index, valid with any calc enable
- wr_hy_en_o  out  1  Hy write-back strobe
- wr_ez_en_o  out  1  Ez write-back strobe, covering Ez and source results
- wr_addr_o  out  ADDR_WIDTH  write-back index
- tstep_o  out  TSTEP_WIDTH  current timestep

Function
REQ-005 SHALL implement the FSM IDLE -> HY -> HY_DRAIN -> EZ -> EZ_DRAIN -> SRC -> SRC_DRAIN -> (HY | DONE) -> IDLE.
REQ-006 SHALL accept start_i only in IDLE, latch num_cells_i, num_steps_i and src_idx_i on that cycle, and ignore those inputs until the run returns to IDLE.
REQ-007 SHALL, on an accepted start with num_cells_i<3 or num_steps_i==0, go directly to DONE, pulse done_o on the next cycle, and assert no enables.
REQ-008 SHALL make the HY phase last N-1 cycles, asserting calc_Hy_en_o=1 with rd_addr_o stepping 0..N-2, starting the cycle after start is accepted.
REQ-009 SHALL make the EZ phase last N-1 cycles, asserting calc_Ez_en_o=1 with rd_addr_o stepping 1..N-1.
REQ-010 SHALL make the SRC phase last 1 cycle, asserting calc_src_en_o=1 with rd_addr_o=src_idx; when src_idx>=N, SRC is skipped and the FSM goes straight to SRC_DRAIN.
REQ-011 SHALL make each *_DRAIN state last exactly CALC_LAT cycles with all calc enables low, so that the next phase never reads a field that is still being written.
REQ-012 SHALL keep at most one calc enable high in any cycle.
REQ-013 SHALL drive wr_hy_en_o as calc_Hy_en_o delayed by CALC_LAT cycles, and wr_ez_en_o as (calc_Ez_en_o | calc_src_en_o) delayed by CALC_LAT cycles.
REQ-014 SHALL drive wr_addr_o as rd_addr_o delayed by CALC_LAT cycles.
REQ-015 SHALL hold tstep_o at 0 at start, increment it on each SRC_DRAIN exit, and on the exit where tstep_o+1==num_steps go to DONE, otherwise back to HY.
REQ-016 SHALL make each timestep last 2(N-1)+1+3*CALC_LAT cycles; when SRC is skipped it lasts one cycle fewer.
REQ-017 SHALL hold busy_o=1 from the cycle after start acceptance through the DONE cycle, and assert done_o only in DONE.
REQ-018 SHALL NOT wrap the cell counter past N-1, and SHALL let the tstep counter saturate only via the terminal compare.
REQ-019 SHALL treat start_i asserted in the DONE cycle as ignored; a new run requires start_i in IDLE.

Reset
REQ-020 SHALL, on RST=1 at a clock edge (including mid-run), enter IDLE and force every output and all delay-line contents to 0.
REQ-021 SHALL NOT emit any write strobe for operations that were in flight when reset asserted.

Configuration
REQ-022 SHALL, with FDTD_SRC_INJECT_EN defined, execute the SRC and SRC_DRAIN states as specified.
REQ-023 SHALL, without FDTD_SRC_INJECT_EN, tie calc_src_en_o to 0, remove SRC/SRC_DRAIN (EZ_DRAIN exits to HY or DONE and performs the tstep update), and make a timestep last 2(N-1)+2*CALC_LAT cycles.

Structure
REQ-024 SHALL place the FSM state enum typedef and the CALC_LAT legal-range constants in the shared package fdtd_pkg.
REQ-025 SHALL implement the enable/address delay as one sub-module, fdtd_delay_line, parameterised by width and depth and reset synchronously.

Verification
REQ-026 Bench SHALL cover: N=8, steps=1, src=3, LAT=2, macro on -> 7 Hy enables (addr 0..6), 2 idle, 7 Ez enables (addr 1..7), 2 idle, 1 src enable at 3, 2 idle, done_o in DONE; 21 cycles in total.
REQ-027 Bench SHALL cover: same settings, steps=3 -> tstep_o goes 0,1,2, done_o pulses once after 63 step cycles, and wr_* mirrors calc_* shifted by 2 cycles.
REQ-028 Bench SHALL cover: src=9 with N=8 -> no calc_src_en_o, 20-cycle step.
REQ-029 Bench SHALL cover: N=2 or steps=0 -> done_o on the next cycle with zero enables.
REQ-030 Bench SHALL cover: RST at the 5th Ez cycle -> all outputs 0 next cycle, no later write strobes, and a clean restart on start_i.
REQ-031 Bench SHALL cover: macro off, N=8, LAT=2 -> calc_src_en_o never 1 and an 18-cycle step.

Source files
------------

// File: rtl/fdtd_pkg.sv
// Shared types and constants for the FDTD sweep controller.
package fdtd_pkg;

  // Legal range of the downstream calc-stage latency.
  localparam int unsigned CalcLatMin = 1;
  localparam int unsigned CalcLatMax = 8;

  // Sweep FSM states; SRC/SRC_DRAIN are only reachable with FDTD_SRC_INJECT_EN.
  typedef enum logic [2:0] {
    StIdle,
    StHy,
    StHyDrain,
    StEz,
    StEzDrain,
    StSrc,
    StSrcDrain,
    StDone
  } state_t;

endpackage

// File: rtl/fdtd_delay_line.sv
// Fixed-depth shift register with synchronous active-high clear.
module fdtd_delay_line #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  // Shift one stage per cycle; clearing drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/fdtd_sweep_ctrl.sv
// FDTD 1-D sweep controller: sequences Hy, Ez and (optionally) source-injection
// passes over N cells per timestep, with drain gaps covering the calc latency.
// Build option: define FDTD_SRC_INJECT_EN to enable the SRC/SRC_DRAIN phase.
module fdtd_sweep_ctrl
  import fdtd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned TSTEP_WIDTH = 16,
  parameter int unsigned CALC_LAT    = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  num_cells_i,
  input  logic [TSTEP_WIDTH-1:0] num_steps_i,
  input  logic [ADDR_WIDTH-1:0]  src_idx_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   calc_Hy_en_o,
  output logic                   calc_Ez_en_o,
  output logic                   calc_src_en_o,
  output logic [ADDR_WIDTH-1:0]  rd_addr_o,
  output logic                   wr_hy_en_o,
  output logic                   wr_ez_en_o,
  output logic [ADDR_WIDTH-1:0]  wr_addr_o,
  output logic [TSTEP_WIDTH-1:0] tstep_o
);

  if (CALC_LAT < CalcLatMin || CALC_LAT > CalcLatMax) begin : gen_bad_lat
    $error("CALC_LAT out of range");
  end

  localparam logic [ADDR_WIDTH-1:0]  AOne   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  ATwo   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0]  AThree = ADDR_WIDTH'(3);
  localparam logic [TSTEP_WIDTH-1:0] TOne   = TSTEP_WIDTH'(1);
  localparam logic [3:0]             LatLast = 4'(CALC_LAT - 1);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [3:0]             lat_q, lat_d;
  logic [TSTEP_WIDTH-1:0] tstep_q, tstep_d;
  logic [ADDR_WIDTH-1:0]  cells_q;
  logic [TSTEP_WIDTH-1:0] steps_q;
  logic                   hy_en, ez_en, src_en;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   last_step;
  logic                   accept;

`ifdef FDTD_SRC_INJECT_EN
  logic [ADDR_WIDTH-1:0]  src_q;
`else
  logic unused_src;
  assign unused_src = ^src_idx_i;
`endif

  assign accept    = (state_q == StIdle) && start_i;
  assign last_step = (tstep_q + TOne) == steps_q;

  // State, counters and timestep register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lat_q   <= '0;
      tstep_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      tstep_q <= tstep_d;
    end
  end

  // Run parameters are captured only when a start is accepted in IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cells_q <= '0;
      steps_q <= '0;
`ifdef FDTD_SRC_INJECT_EN
      src_q   <= '0;
`endif
    end else if (accept) begin
      cells_q <= num_cells_i;
      steps_q <= num_steps_i;
`ifdef FDTD_SRC_INJECT_EN
      src_q   <= src_idx_i;
`endif
    end
  end

  // Next-state logic and per-phase calc enables.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    tstep_d = tstep_q;
    hy_en   = 1'b0;
    ez_en   = 1'b0;
    src_en  = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d   = '0;
          lat_d   = '0;
          tstep_d = '0;
          state_d = (num_cells_i < AThree || num_steps_i == '0) ? StDone : StHy;
        end
      end
      StHy: begin
        hy_en   = 1'b1;
        rd_addr = cnt_q;
        if (cnt_q == cells_q - ATwo) begin
          cnt_d   = AOne;  // Ez pass starts at cell 1
          state_d = StHyDrain;
        end else begin
          cnt_d = cnt_q + AOne;
        end
      end
      StHyDrain: begin
        if (lat_q == LatLast) begin
          lat_d   = '0;
          state_d = StEz;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StEz: begin
        ez_en   = 1'b1;
        rd_addr = cnt_q;
        if (cnt_q == cells_q - AOne) begin
          cnt_d   = '0;
          state_d = StEzDrain;
        end else begin
          cnt_d = cnt_q + AOne;
        end
      end
      StEzDrain: begin
        if (lat_q == LatLast) begin
          lat_d = '0;
`ifdef FDTD_SRC_INJECT_EN
          // Out-of-grid source: skip injection but keep the drain.
          state_d = (src_q < cells_q) ? StSrc : StSrcDrain;
`else
          tstep_d = tstep_q + TOne;
          state_d = last_step ? StDone : StHy;
`endif
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
`ifdef FDTD_SRC_INJECT_EN
      StSrc: begin
        src_en  = 1'b1;
        rd_addr = src_q;
        state_d = StSrcDrain;
      end
      StSrcDrain: begin
        if (lat_q == LatLast) begin
          lat_d   = '0;
          tstep_d = tstep_q + TOne;
          state_d = last_step ? StDone : StHy;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Write-back strobes and address trail the calc enables by CALC_LAT cycles.
  fdtd_delay_line #(
    .Width (ADDR_WIDTH + 2),
    .Depth (CALC_LAT)
  ) u_delay (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   ({hy_en, ez_en | src_en, rd_addr}),
    .q_o   ({wr_hy_en_o, wr_ez_en_o, wr_addr_o})
  );

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign calc_Hy_en_o  = hy_en;
  assign calc_Ez_en_o  = ez_en;
  assign calc_src_en_o = src_en;
  assign rd_addr_o     = rd_addr;
  assign tstep_o       = tstep_q;

endmodule

// File: tb/tb_fdtd_sweep_ctrl.sv
// Self-checking bench for fdtd_sweep_ctrl; follows FDTD_SRC_INJECT_EN like the RTL.
module tb_fdtd_sweep_ctrl;

  localparam int AW  = 10;
  localparam int TW  = 16;
  localparam int LAT = 2;
`ifdef FDTD_SRC_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] num_cells_i = '0;
  logic [TW-1:0] num_steps_i = '0;
  logic [AW-1:0] src_idx_i = '0;
  logic          busy_o, done_o, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic          wr_hy_en_o, wr_ez_en_o;
  logic [TW-1:0] tstep_o;
  logic [7+2*AW+TW-1:0] all_out;

  int checks = 0;
  int errors = 0;

  fdtd_sweep_ctrl #(
    .ADDR_WIDTH  (AW),
    .TSTEP_WIDTH (TW),
    .CALC_LAT    (LAT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .start_i       (start_i),
    .num_cells_i   (num_cells_i),
    .num_steps_i   (num_steps_i),
    .src_idx_i     (src_idx_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .calc_Hy_en_o  (calc_Hy_en_o),
    .calc_Ez_en_o  (calc_Ez_en_o),
    .calc_src_en_o (calc_src_en_o),
    .rd_addr_o     (rd_addr_o),
    .wr_hy_en_o    (wr_hy_en_o),
    .wr_ez_en_o    (wr_ez_en_o),
    .wr_addr_o     (wr_addr_o),
    .tstep_o       (tstep_o)
  );

  always #5 CLK = ~CLK;

  assign all_out = {busy_o, done_o, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o, wr_hy_en_o,
                    wr_ez_en_o, rd_addr_o, wr_addr_o, tstep_o};

  // Expected activity of one cycle, as the sweep schedule describes it.
  typedef struct packed {
    logic          busy;
    logic          done;
    logic          hy;
    logic          ez;
    logic          src;
    logic [AW-1:0] rd;
    logic [TW-1:0] ts;
    logic          ts_v;
  } exp_t;

  function automatic exp_t mk(input logic b, input logic d, input logic h, input logic z,
                              input logic s, input int rd, input int ts, input logic tv);
    exp_t e;
    e.busy = b; e.done = d; e.hy = h; e.ez = z; e.src = s;
    e.rd = rd[AW-1:0]; e.ts = ts[TW-1:0]; e.ts_v = tv;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Runs one sweep and compares every cycle against the schedule built from N/steps/src.
  task automatic run_case(input int n, input int steps, input int src, input string name,
                          output int hy_cnt, output int ez_cnt, output int src_cnt,
                          output int done_cnt, output int done_at);
    exp_t tr[$];
    exp_t e, w;
    exp_t z;
    logic [7+2*AW+TW-1:0] obs, expv;
    int last;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    if (n < 3 || steps == 0) begin
      tr.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    end else begin
      for (int t = 0; t < steps; t++) begin
        for (int a = 0; a < n - 1; a++) tr.push_back(mk(1, 0, 1, 0, 0, a, t, 1));
        for (int d = 0; d < LAT; d++) tr.push_back(mk(1, 0, 0, 0, 0, 0, t, 1));
        for (int a = 1; a < n; a++) tr.push_back(mk(1, 0, 0, 1, 0, a, t, 1));
        for (int d = 0; d < LAT; d++) tr.push_back(mk(1, 0, 0, 0, 0, 0, t, 1));
        if (INJ) begin
          if (src < n) tr.push_back(mk(1, 0, 0, 0, 1, src, t, 1));
          for (int d = 0; d < LAT; d++) tr.push_back(mk(1, 0, 0, 0, 0, 0, t, 1));
        end
      end
      tr.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    end
    last = tr.size() - 1;
    hy_cnt = 0; ez_cnt = 0; src_cnt = 0; done_cnt = 0; done_at = -1;

    num_cells_i = AW'(n);
    num_steps_i = TW'(steps);
    src_idx_i   = AW'(src);
    start_i     = 1'b1;
    next_cycle();
    for (int k = 0; k <= last + 2; k++) begin
      e = (k <= last) ? tr[k] : z;
      w = (k >= LAT && k - LAT <= last) ? tr[k-LAT] : z;
      expv = {e.busy, e.done, e.hy, e.ez, e.src, w.hy, w.ez | w.src,
              (e.hy | e.ez | e.src) ? e.rd : '0, (w.hy | w.ez | w.src) ? w.rd : '0,
              e.ts_v ? e.ts : '0};
      obs  = {busy_o, done_o, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o, wr_hy_en_o,
              wr_ez_en_o, (e.hy | e.ez | e.src) ? rd_addr_o : '0,
              (w.hy | w.ez | w.src) ? wr_addr_o : '0, e.ts_v ? tstep_o : '0};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs, expv);
      end
      hy_cnt  += int'(calc_Hy_en_o);
      ez_cnt  += int'(calc_Ez_en_o);
      src_cnt += int'(calc_src_en_o);
      done_cnt += int'(done_o);
      if (done_o === 1'b1 && done_at < 0) done_at = k;
      // Parameter inputs and start_i wiggle while busy; a start in DONE must be ignored.
      if (k < last) begin
        start_i     = 1'($urandom_range(0, 1));
        num_cells_i = AW'($urandom);
        num_steps_i = TW'($urandom);
        src_idx_i   = AW'($urandom);
      end else begin
        start_i = (k == last);
      end
      next_cycle();
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) next_cycle();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", all_out);
    end
    RST = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_step();
    int hy, ez, sr, dn, at;
    run_case(8, 1, 3, "single_step", hy, ez, sr, dn, at);
    checks++;
    if (at !== (INJ ? 21 : 18) || hy !== 7 || ez !== 7 || sr !== (INJ ? 1 : 0) || dn !== 1) begin
      errors++;
      $display("FAIL single_step_totals: got done_at=%0d hy=%0d ez=%0d src=%0d done=%0d",
               at, hy, ez, sr, dn);
    end
  endtask

  task automatic test_multi_step();
    int hy, ez, sr, dn, at;
    run_case(8, 3, 3, "multi_step", hy, ez, sr, dn, at);
    checks++;
    if (at !== (INJ ? 63 : 54) || hy !== 21 || sr !== (INJ ? 3 : 0) || dn !== 1) begin
      errors++;
      $display("FAIL multi_step_totals: got done_at=%0d hy=%0d src=%0d done=%0d (want 1 done)",
               at, hy, sr, dn);
    end
  endtask

  task automatic test_src_skip();
    int hy, ez, sr, dn, at;
    run_case(8, 1, 9, "src_skip", hy, ez, sr, dn, at);
    checks++;
    if (sr !== 0 || at !== (INJ ? 20 : 18)) begin
      errors++;
      $display("FAIL src_skip_totals: got src=%0d done_at=%0d", sr, at);
    end
  endtask

  task automatic test_degenerate();
    int hy, ez, sr, dn, at;
    int ns [3] = '{2, 8, 0};
    int st [3] = '{5, 0, 1};
    for (int i = 0; i < 3; i++) begin
      run_case(ns[i], st[i], 1, "degenerate", hy, ez, sr, dn, at);
      checks++;
      if (at !== 0 || hy + ez + sr !== 0 || dn !== 1) begin
        errors++;
        $display("FAIL degenerate_%0d: got done_at=%0d enables=%0d done=%0d",
                 i, at, hy + ez + sr, dn);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int hy, ez, sr, dn, at;
    num_cells_i = AW'(8);
    num_steps_i = TW'(1);
    src_idx_i   = AW'(3);
    start_i     = 1'b1;
    next_cycle();
    start_i = 1'b0;
    repeat (13) next_cycle();  // 7 Hy + 2 drain + 4 Ez cycles
    checks++;
    if (calc_Ez_en_o !== 1'b1 || rd_addr_o !== AW'(5)) begin
      errors++;
      $display("FAIL mid_run_ez5: got ez=%b addr=%0d expected ez=1 addr=5",
               calc_Ez_en_o, rd_addr_o);
    end
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: got %h expected 0", all_out);
    end
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      checks++;
      if (all_out !== '0) begin
        errors++;
        $display("FAIL post_reset_quiet cycle %0d: got %h expected 0", k, all_out);
      end
    end
    run_case(8, 1, 3, "restart", hy, ez, sr, dn, at);
    checks++;
    if (at !== (INJ ? 21 : 18)) begin
      errors++;
      $display("FAIL restart_len: got %0d expected %0d", at, INJ ? 21 : 18);
    end
  endtask

  task automatic test_back_to_back();
    int hy, ez, sr, dn, at;
    int n, steps, src;
    for (int i = 0; i < 8; i++) begin
      n     = $urandom_range(3, 16);
      steps = $urandom_range(1, 3);
      src   = $urandom_range(0, n + 1);
      run_case(n, steps, src, "random", hy, ez, sr, dn, at);
      checks++;
      if (hy !== steps * (n - 1) || ez !== steps * (n - 1) ||
          sr !== ((INJ && src < n) ? steps : 0) || dn !== 1) begin
        errors++;
        $display("FAIL random_%0d n=%0d steps=%0d src=%0d: got hy=%0d ez=%0d src=%0d done=%0d",
                 i, n, steps, src, hy, ez, sr, dn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_multi_step();
    test_src_skip();
    test_degenerate();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
